// File: rtl/core_id_scoreboard.sv
// ID-stage register scoreboard: per-register pending-writer counts, RAW/structural stall, EX forward select.
// Outputs are combinational from state plus current inputs; stalls ID by holding id_stall, never drops issues.
module core_id_scoreboard #(
    parameter int RFIDX_W = 5,
    parameter int CNT_W   = 2,
    parameter int INFL_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic               id_fire,
    input  logic               id_rs1_ren,
    input  logic               id_rs2_ren,
    input  logic [RFIDX_W-1:0] id_rs1_idx,
    input  logic [RFIDX_W-1:0] id_rs2_idx,
    input  logic               id_rd_wen,
    input  logic [RFIDX_W-1:0] id_rd_idx,
    input  logic               ex_fwd_valid,
    input  logic [RFIDX_W-1:0] ex_fwd_idx,
    input  logic               wb_valid,
    input  logic [RFIDX_W-1:0] wb_rd_idx,
    input  logic               flush,
    output logic               id_stall,
    output logic               rs1_fwd,
    output logic               rs2_fwd,
    output logic [INFL_W-1:0]  inflight,
    output logic               sb_full
);

    localparam int NREG = 1 << RFIDX_W;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [INFL_W-1:0] INFL_MAX = '1;
    localparam logic [INFL_W-1:0] INFL_ONE = INFL_W'(1);

    logic [CNT_W-1:0]  r_cnt [NREG];
    logic [INFL_W-1:0] r_inflight;

    logic              w_iss;
    logic              w_wb;
    logic [CNT_W-1:0]  w_cnt_rs1;
    logic [CNT_W-1:0]  w_cnt_rs2;
    logic [CNT_W-1:0]  w_cnt_rd;
    logic              w_hz1;
    logic              w_hz2;
    logic              w_fwd1;
    logic              w_fwd2;
    logic              w_struct;
    logic              w_full;

    assign w_iss = id_fire & id_rd_wen & (id_rd_idx != '0);
    // WB to an idle counter is dropped so late writebacks after reset/flush cannot underflow.
    assign w_wb  = wb_valid & (wb_rd_idx != '0) & (r_cnt[wb_rd_idx] != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_inflight <= '0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_inflight <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_iss && (id_rd_idx == RFIDX_W'(i)) && !(w_wb && (wb_rd_idx == RFIDX_W'(i)))) begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end else if (w_wb && (wb_rd_idx == RFIDX_W'(i)) && !(w_iss && (id_rd_idx == RFIDX_W'(i)))) begin
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
                end
            end
            if (w_iss && !w_wb) begin
                r_inflight <= r_inflight + INFL_ONE;
            end else if (w_wb && !w_iss) begin
                r_inflight <= r_inflight - INFL_ONE;
            end
        end
    end

    assign w_cnt_rs1 = r_cnt[id_rs1_idx];
    assign w_cnt_rs2 = r_cnt[id_rs2_idx];
    assign w_cnt_rd  = r_cnt[id_rd_idx];
    assign w_full    = (r_inflight == INFL_MAX);

    assign w_hz1 = id_rs1_ren & (id_rs1_idx != '0) & (w_cnt_rs1 != '0);
    assign w_hz2 = id_rs2_ren & (id_rs2_idx != '0) & (w_cnt_rs2 != '0);

    // Forwarding only covers a single pending writer; with two, EX may hold the older one.
    assign w_fwd1 = w_hz1 & (w_cnt_rs1 == CNT_ONE) & ex_fwd_valid & (ex_fwd_idx == id_rs1_idx);
    assign w_fwd2 = w_hz2 & (w_cnt_rs2 == CNT_ONE) & ex_fwd_valid & (ex_fwd_idx == id_rs2_idx);

    assign w_struct = id_rd_wen & (id_rd_idx != '0) & ((w_cnt_rd == CNT_MAX) | w_full);

    assign id_stall = id_valid & ((w_hz1 & ~w_fwd1) | (w_hz2 & ~w_fwd2) | w_struct);
    assign rs1_fwd  = w_fwd1;
    assign rs2_fwd  = w_fwd2;
    assign inflight = r_inflight;
    assign sb_full  = w_full;

endmodule

// File: tb/tb_core_id_scoreboard.sv
// Directed-vector bench for core_id_scoreboard: table of per-cycle inputs and hand-computed outputs.
module tb_core_id_scoreboard;

    logic       clk;
    logic       rst;
    logic       id_valid, id_fire, id_rs1_ren, id_rs2_ren, id_rd_wen;
    logic [4:0] id_rs1_idx, id_rs2_idx, id_rd_idx;
    logic       ex_fwd_valid, wb_valid, flush;
    logic [4:0] ex_fwd_idx, wb_rd_idx;
    logic       id_stall, rs1_fwd, rs2_fwd, sb_full;
    logic [3:0] inflight;

    int total;
    int bad;

    core_id_scoreboard #(.RFIDX_W(5), .CNT_W(2), .INFL_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_fire      (id_fire),
        .id_rs1_ren   (id_rs1_ren),
        .id_rs2_ren   (id_rs2_ren),
        .id_rs1_idx   (id_rs1_idx),
        .id_rs2_idx   (id_rs2_idx),
        .id_rd_wen    (id_rd_wen),
        .id_rd_idx    (id_rd_idx),
        .ex_fwd_valid (ex_fwd_valid),
        .ex_fwd_idx   (ex_fwd_idx),
        .wb_valid     (wb_valid),
        .wb_rd_idx    (wb_rd_idx),
        .flush        (flush),
        .id_stall     (id_stall),
        .rs1_fwd      (rs1_fwd),
        .rs2_fwd      (rs2_fwd),
        .inflight     (inflight),
        .sb_full      (sb_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       vld, fire, r1en;
        logic [4:0] r1;
        logic       r2en;
        logic [4:0] r2;
        logic       wen;
        logic [4:0] rd;
        logic       fv;
        logic [4:0] fi;
        logic       wv;
        logic [4:0] wi;
        logic       fl;
        logic       e_stall, e_f1, e_f2;
        logic [3:0] e_infl;
        logic       e_full;
    } vec_t;

    function automatic vec_t v(string n, bit vld, bit fire, bit r1en, int r1, bit r2en, int r2,
                               bit wen, int rd, bit fv, int fi, bit wv, int wi, bit fl,
                               bit es, bit ef1, bit ef2, int einfl, bit efull);
        vec_t t;
        t.name = n;   t.vld = vld;  t.fire = fire;
        t.r1en = r1en; t.r1 = 5'(r1); t.r2en = r2en; t.r2 = 5'(r2);
        t.wen = wen;  t.rd = 5'(rd); t.fv = fv; t.fi = 5'(fi);
        t.wv = wv;    t.wi = 5'(wi); t.fl = fl;
        t.e_stall = es; t.e_f1 = ef1; t.e_f2 = ef2; t.e_infl = 4'(einfl); t.e_full = efull;
        return t;
    endfunction

    task automatic chk(string n, string what, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s.%s actual=%0d required=%0d", n, what, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        id_valid = t.vld;   id_fire = t.fire;
        id_rs1_ren = t.r1en; id_rs1_idx = t.r1;
        id_rs2_ren = t.r2en; id_rs2_idx = t.r2;
        id_rd_wen = t.wen;  id_rd_idx = t.rd;
        ex_fwd_valid = t.fv; ex_fwd_idx = t.fi;
        wb_valid = t.wv;    wb_rd_idx = t.wi;
        flush = t.fl;
    endtask

    task automatic apply(vec_t t);
        @(negedge clk);
        drive(t);
        #1;
        chk(t.name, "id_stall", int'(id_stall), int'(t.e_stall));
        chk(t.name, "rs1_fwd",  int'(rs1_fwd),  int'(t.e_f1));
        chk(t.name, "rs2_fwd",  int'(rs2_fwd),  int'(t.e_f2));
        chk(t.name, "inflight", int'(inflight), int'(t.e_infl));
        chk(t.name, "sb_full",  int'(sb_full),  int'(t.e_full));
        if (t.fire) chk(t.name, "fire_while_stalled", int'(id_stall), 0);
    endtask

    vec_t tbl[$];

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(v("zero", 0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));

        // In reset, every output is quiet regardless of inputs.
        apply(v("rst_idle", 0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        apply(v("rst_any",  1,0,1,5,1,7,1,4,1,5,1,5,0, 0,0,0,0,0));
        @(negedge clk);
        drive(v("zero", 0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        rst = 1'b0;

        //          name           vld fi r1e r1 r2e r2 wen rd fv fi wv wi fl | st f1 f2 inf full
        tbl.push_back(v("issue_x5",     1,1,0,0,0,0,1,5,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(v("raw_fwd",      1,0,1,5,0,0,0,0,1,5,0,0,0, 0,1,0,1,0));
        tbl.push_back(v("raw_nofwd",    1,0,1,5,0,0,0,0,0,0,0,0,0, 1,0,0,1,0));
        tbl.push_back(v("raw_wb_same",  1,0,1,5,0,0,0,0,0,0,1,5,0, 1,0,0,1,0));
        tbl.push_back(v("raw_release",  1,1,1,5,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(v("x7_w1",        1,1,0,0,0,0,1,7,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(v("x7_w2",        1,1,0,0,0,0,1,7,0,0,0,0,0, 0,0,0,1,0));
        tbl.push_back(v("x7_cnt2_fwd",  1,0,1,7,0,0,0,0,1,7,0,0,0, 1,0,0,2,0));
        tbl.push_back(v("x7_rs2_wb",    1,0,0,0,1,7,0,0,1,7,1,7,0, 1,0,0,2,0));
        tbl.push_back(v("x7_cnt1_fwd",  1,1,0,0,1,7,0,0,1,7,0,0,0, 0,0,1,1,0));
        tbl.push_back(v("rd_x0_issue",  1,1,1,0,0,0,1,0,0,0,0,0,0, 0,0,0,1,0));
        tbl.push_back(v("wb_x0",        0,0,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,1,0));
        tbl.push_back(v("wb_x9_zero",   0,0,0,0,0,0,0,0,0,0,1,9,0, 0,0,0,1,0));
        tbl.push_back(v("x9_still0",    1,0,1,9,0,0,0,0,0,0,0,0,0, 0,0,0,1,0));
        tbl.push_back(v("x3_issue",     1,1,0,0,0,0,1,3,0,0,0,0,0, 0,0,0,1,0));
        tbl.push_back(v("x3_iss_wb",    1,1,0,0,0,0,1,3,0,0,1,3,0, 0,0,0,2,0));
        tbl.push_back(v("x3_still1",    1,0,1,3,0,0,0,0,1,3,0,0,0, 0,1,0,2,0));
        tbl.push_back(v("wb_x7",        0,0,0,0,0,0,0,0,0,0,1,7,0, 0,0,0,2,0));
        tbl.push_back(v("wb_x3",        0,0,0,0,0,0,0,0,0,0,1,3,0, 0,0,0,1,0));
        tbl.push_back(v("x4_w1",        1,1,0,0,0,0,1,4,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(v("x4_w2",        1,1,0,0,0,0,1,4,0,0,0,0,0, 0,0,0,1,0));
        tbl.push_back(v("x4_w3",        1,1,0,0,0,0,1,4,0,0,0,0,0, 0,0,0,2,0));
        tbl.push_back(v("x4_fourth",    1,0,0,0,0,0,1,4,0,0,0,0,0, 1,0,0,3,0));
        tbl.push_back(v("x4_other_rd",  1,0,0,0,0,0,1,6,0,0,0,0,0, 0,0,0,3,0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Fill the aggregate counter to its ceiling with writers to x10..x21.
        for (int i = 0; i < 12; i++)
            apply(v("fill", 1,1,0,0,0,0,1,10+i,0,0,0,0,0, 0,0,0,3+i,0));
        apply(v("full_wr",     1,0,0,0,0,0,1,25,0,0,0,0,0, 1,0,0,15,1));
        apply(v("full_nowr",   1,1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,15,1));
        apply(v("full_x0",     1,0,0,0,0,0,1,0,0,0,0,0,0, 0,0,0,15,1));
        apply(v("wb_x10",      0,0,0,0,0,0,0,0,0,0,1,10,0, 0,0,0,15,1));
        apply(v("flush_all",   1,1,0,0,0,0,1,22,0,0,1,11,1, 0,0,0,14,0));
        apply(v("post_flush",  1,0,1,4,1,12,1,4,0,0,0,0,0, 0,0,0,0,0));

        // Asynchronous reset between edges must clear state without waiting for a clock.
        apply(v("pre_rst1",    1,1,0,0,0,0,1,8,0,0,0,0,0, 0,0,0,0,0));
        apply(v("pre_rst2",    1,1,0,0,0,0,1,8,0,0,0,0,0, 0,0,0,1,0));
        @(negedge clk);
        drive(v("rd8", 1,0,1,8,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        #1;
        chk("async_rst_pre", "id_stall", int'(id_stall), 1);
        chk("async_rst_pre", "inflight", int'(inflight), 2);
        #1 rst = 1'b1;
        #1;
        chk("async_rst", "id_stall", int'(id_stall), 0);
        chk("async_rst", "inflight", int'(inflight), 0);
        chk("async_rst", "sb_full",  int'(sb_full),  0);
        #1 rst = 1'b0;
        apply(v("wb_after_rst", 0,0,0,0,0,0,0,0,0,0,1,8,0, 0,0,0,0,0));
        apply(v("final_rd8",    1,0,1,8,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
